// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

    localparam int unsigned XLEN_DEFAULT         = 32;
    localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
    localparam int unsigned PC_STEP              = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_FAULT
    } state_t;

    // Instruction addresses must be 4-byte aligned.
    function automatic logic word_aligned(input logic [1:0] low_bits);
        return low_bits == 2'b00;
    endfunction

endpackage

// File: rtl/fetch_inst_buffer.sv
// Single-entry holding register for a fetched instruction and its PC.
module fetch_inst_buffer
    import fetch_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
) (
    input  logic            CLK,
    input  logic            Reset,
    input  logic            load,
    input  logic            clear,
    input  logic [XLEN-1:0] load_data,
    input  logic [XLEN-1:0] load_pc,
    output logic            valid,
    output logic [XLEN-1:0] data,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus_4
);

    // Clearing drops only the valid flag; payload is don't-care until the next load.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            valid     <= 1'b0;
            data      <= '0;
            pc        <= '0;
            pc_plus_4 <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid     <= 1'b1;
            data      <= load_data;
            pc        <= load_pc;
            pc_plus_4 <= load_pc + XLEN'(PC_STEP);
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Handshake-aware program counter: one outstanding fetch, redirect handling,
// stale-response discard and a sticky misaligned-target fault.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int unsigned     XLEN         = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEFAULT)
) (
    input  logic            CLK,
    input  logic            Reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst_data,
    output logic [XLEN-1:0] inst_pc,
    output logic [XLEN-1:0] inst_pc_plus_4,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    output logic            misalign_fault,
    output logic [XLEN-1:0] fault_pc
);

    state_t          state, state_next;
    logic [XLEN-1:0] pc, pc_next;
    logic [XLEN-1:0] fault_pc_next;
    logic            discard, discard_next;
    logic            fault_next;
    logic            buf_load, buf_clear;
    logic            redirect_ok, redirect_bad, take_fault;

    assign redirect_ok  = redirect_valid && word_aligned(redirect_target[1:0]);
    assign redirect_bad = redirect_valid && !word_aligned(redirect_target[1:0]);
    assign take_fault   = redirect_bad &&
                          (state == S_REQ || state == S_WAIT || state == S_HOLD);

    assign imem_req_valid = (state == S_REQ);
    assign imem_req_addr  = pc;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state          <= S_IDLE;
            pc             <= RESET_VECTOR;
            discard        <= 1'b0;
            misalign_fault <= 1'b0;
            fault_pc       <= '0;
        end else begin
            state          <= state_next;
            pc             <= pc_next;
            discard        <= discard_next;
            misalign_fault <= fault_next;
            fault_pc       <= fault_pc_next;
        end
    end

    always_comb begin
        state_next    = state;
        pc_next       = pc;
        discard_next  = discard;
        fault_next    = misalign_fault;
        fault_pc_next = fault_pc;
        buf_load      = 1'b0;
        buf_clear     = 1'b0;

        case (state)
            S_IDLE: state_next = S_REQ;

            S_REQ: begin
                // A request accepted alongside a redirect is already stale.
                if (imem_req_ready) begin
                    state_next   = S_WAIT;
                    discard_next = redirect_ok;
                end
                if (redirect_ok) pc_next = redirect_target;
            end

            S_WAIT: begin
                if (imem_rsp_valid) begin
                    discard_next = 1'b0;
                    if (discard || redirect_ok) begin
                        state_next = S_REQ;
                    end else begin
                        buf_load   = 1'b1;
                        state_next = S_HOLD;
                    end
                end else if (redirect_ok) begin
                    discard_next = 1'b1;
                end
                if (redirect_ok) pc_next = redirect_target;
            end

            S_HOLD: begin
                if (redirect_ok) begin
                    pc_next    = redirect_target;
                    buf_clear  = 1'b1;
                    state_next = S_REQ;
                end else if (inst_ready) begin
                    pc_next    = pc + XLEN'(PC_STEP);
                    buf_clear  = 1'b1;
                    state_next = S_REQ;
                end
            end

            S_FAULT: state_next = S_FAULT;

            default: state_next = S_IDLE;
        endcase

        // Misaligned redirect overrides everything and freezes the pc.
        if (take_fault) begin
            state_next    = S_FAULT;
            pc_next       = pc;
            discard_next  = 1'b0;
            fault_next    = 1'b1;
            fault_pc_next = redirect_target;
            buf_load      = 1'b0;
            buf_clear     = 1'b1;
        end
    end

    fetch_inst_buffer #(.XLEN(XLEN)) u_inst_buffer (
        .CLK       (CLK),
        .Reset     (Reset),
        .load      (buf_load),
        .clear     (buf_clear),
        .load_data (imem_rsp_data),
        .load_pc   (pc),
        .valid     (inst_valid),
        .data      (inst_data),
        .pc        (inst_pc),
        .pc_plus_4 (inst_pc_plus_4)
    );

endmodule
